// File: rtl/syncram_access_ctrl.sv
// rtl/syncram_access_ctrl.sv - round-robin write / 4-port read sequencer in front of syncRAM
// Optional macro SYNCRAM_INIT_CLEAR_EN adds a post-reset zero-fill sweep (busy high while it runs).
module syncram_access_ctrl #(
  parameter int AW   = 8,
  parameter int DW   = 8,
  parameter int NCLI = 4
) (
  input  logic                Clk,
  input  logic                Rst_n,
  input  logic [NCLI-1:0]     wrReq,
  input  logic [NCLI*AW-1:0]  wrAddrBus,
  input  logic [NCLI*DW-1:0]  wrDataBus,
  output logic [NCLI-1:0]     wrGnt,
  input  logic [NCLI-1:0]     rdReq,
  input  logic [NCLI*AW-1:0]  rdAddrBus,
  output logic [NCLI-1:0]     rdGnt,
  output logic [NCLI*DW-1:0]  rdDataBus,
  output logic [NCLI-1:0]     rdValid,
  output logic                busy,
  output logic [DW-1:0]       ramDataIn,
  output logic [AW-1:0]       ramWriteAddr,
  output logic [NCLI*AW-1:0]  ramReadAddrBus,
  output logic                ramChipSelect,
  output logic                ramWriteEnable,
  output logic                ramReadEnable,
  input  logic [NCLI*DW-1:0]  ramDOutBus
);

  logic              running;
  logic [1:0]        ptr;
  logic [1:0]        win;
  logic              wr_any;
  logic [AW-1:0]     win_addr;
  logic [DW-1:0]     win_data;
  logic [NCLI-1:0]   rd_pend;
  logic [NCLI*DW-1:0] rd_hold;

`ifdef SYNCRAM_INIT_CLEAR_EN
  typedef enum logic [0:0] {ST_CLR, ST_RUN} state_t;
  state_t        state, state_nxt;
  logic [AW-1:0] clr_cnt;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state   <= ST_CLR;
      clr_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_CLR) clr_cnt <= clr_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    if (state == ST_CLR && clr_cnt == {AW{1'b1}}) state_nxt = ST_RUN;
  end

  assign running = (state == ST_RUN);
  assign busy    = (state == ST_CLR);
`else
  assign running = 1'b1;
  assign busy    = 1'b0;
`endif

  // Scan from ptr upward; first requester wins.
  always_comb begin
    wr_any = 1'b0;
    win    = ptr;
    for (int k = 0; k < NCLI; k++) begin
      if (!wr_any && wrReq[ptr + 2'(k)]) begin
        wr_any = 1'b1;
        win    = ptr + 2'(k);
      end
    end
    wr_any = wr_any & running;
    wrGnt  = '0;
    if (wr_any) wrGnt[win] = 1'b1;
  end

  assign win_addr = wrAddrBus[win*AW +: AW];
  assign win_data = wrDataBus[win*DW +: DW];

  // A read colliding with this cycle's write address waits one cycle to see the new data.
  always_comb begin
    rdGnt = '0;
    for (int i = 0; i < NCLI; i++) begin
      rdGnt[i] = running & rdReq[i] &
                 ~(wr_any && (rdAddrBus[i*AW +: AW] == win_addr));
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      ptr            <= '0;
      ramDataIn      <= '0;
      ramWriteAddr   <= '0;
      ramReadAddrBus <= '0;
      ramChipSelect  <= 1'b0;
      ramWriteEnable <= 1'b0;
      ramReadEnable  <= 1'b0;
      rd_pend        <= '0;
      rdValid        <= '0;
      rd_hold        <= '0;
    end else begin
      if (running) begin
        ramWriteEnable <= wr_any;
        ramReadEnable  <= |rdGnt;
        ramChipSelect  <= wr_any | (|rdGnt);
        if (wr_any) begin
          ptr          <= win + 2'd1;
          ramWriteAddr <= win_addr;
          ramDataIn    <= win_data;
        end
        for (int i = 0; i < NCLI; i++) begin
          if (rdGnt[i]) ramReadAddrBus[i*AW +: AW] <= rdAddrBus[i*AW +: AW];
        end
      end
`ifdef SYNCRAM_INIT_CLEAR_EN
      else begin
        ramWriteAddr   <= clr_cnt;
        ramDataIn      <= '0;
        ramChipSelect  <= 1'b1;
        ramWriteEnable <= 1'b1;
        ramReadEnable  <= 1'b0;
      end
`endif
      rd_pend <= rdGnt;
      rdValid <= rd_pend;
      for (int i = 0; i < NCLI; i++) begin
        if (rdValid[i]) rd_hold[i*DW +: DW] <= ramDOutBus[i*DW +: DW];
      end
    end
  end

  // RAM output is live during the valid cycle; the hold register keeps it stable afterwards.
  always_comb begin
    rdDataBus = rd_hold;
    for (int i = 0; i < NCLI; i++) begin
      if (rdValid[i]) rdDataBus[i*DW +: DW] = ramDOutBus[i*DW +: DW];
    end
  end

endmodule

// File: tb/tb_syncram_access_ctrl.sv
// tb/tb_syncram_access_ctrl.sv - directed self-checking bench for syncram_access_ctrl with a syncRAM model
module tb_syncram_access_ctrl;
  localparam int AW = 4;
  localparam int DW = 8;

  logic          Clk;
  logic          Rst_n;
  logic [3:0]    wrReq;
  logic [4*AW-1:0] wrAddrBus;
  logic [4*DW-1:0] wrDataBus;
  logic [3:0]    wrGnt;
  logic [3:0]    rdReq;
  logic [4*AW-1:0] rdAddrBus;
  logic [3:0]    rdGnt;
  logic [4*DW-1:0] rdDataBus;
  logic [3:0]    rdValid;
  logic          busy;
  logic [DW-1:0] ramDataIn;
  logic [AW-1:0] ramWriteAddr;
  logic [4*AW-1:0] ramReadAddrBus;
  logic          ramChipSelect;
  logic          ramWriteEnable;
  logic          ramReadEnable;
  logic [4*DW-1:0] ramDOutBus = '0;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] mem [16] = '{default: 8'hEE};

  syncram_access_ctrl #(.AW(AW), .DW(DW), .NCLI(4)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .wrReq(wrReq), .wrAddrBus(wrAddrBus), .wrDataBus(wrDataBus), .wrGnt(wrGnt),
    .rdReq(rdReq), .rdAddrBus(rdAddrBus), .rdGnt(rdGnt),
    .rdDataBus(rdDataBus), .rdValid(rdValid), .busy(busy),
    .ramDataIn(ramDataIn), .ramWriteAddr(ramWriteAddr), .ramReadAddrBus(ramReadAddrBus),
    .ramChipSelect(ramChipSelect), .ramWriteEnable(ramWriteEnable),
    .ramReadEnable(ramReadEnable), .ramDOutBus(ramDOutBus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    if (ramChipSelect && ramWriteEnable) mem[ramWriteAddr] <= ramDataIn;
    if (ramChipSelect && ramReadEnable) begin
      for (int i = 0; i < 4; i++) ramDOutBus[i*DW +: DW] <= mem[ramReadAddrBus[i*AW +: AW]];
    end
  end

  task automatic cyc;
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset;
    Rst_n = 1'b0;
    wrReq = '0; rdReq = '0; wrAddrBus = '0; wrDataBus = '0; rdAddrBus = '0;
    #12;
    total++;
    if ({ramChipSelect, ramWriteEnable, ramReadEnable, rdValid, rdDataBus, ramWriteAddr, ramDataIn, ramReadAddrBus} !== '0) begin
      bad++;
      $display("FAIL reset_regs cs=%b we=%b re=%b vld=%h rdata=%h waddr=%h din=%h raddr=%h exp=all zero",
               ramChipSelect, ramWriteEnable, ramReadEnable, rdValid, rdDataBus, ramWriteAddr, ramDataIn, ramReadAddrBus);
    end
    @(posedge Clk);
    #1;
    Rst_n = 1'b1;
`ifdef SYNCRAM_INIT_CLEAR_EN
    begin
      int n;
      wrReq = 4'b0001;
      #1;
      total++;
      if (wrGnt !== 4'b0000 || busy !== 1'b1) begin
        bad++;
        $display("FAIL clr_block gnt=%b busy=%b exp gnt=0000 busy=1", wrGnt, busy);
      end
      wrReq = '0;
      n = 0;
      while (busy === 1'b1 && n < 40) begin
        n++;
        cyc();
      end
      total++;
      if (n != 16) begin
        bad++;
        $display("FAIL clr_len got=%0d exp=16", n);
      end
    end
`else
    #1;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL busy_idle got=%b exp=0", busy);
    end
`endif
  endtask

  task automatic test_rr_all;
    logic [3:0] eg;
    for (int i = 0; i < 4; i++) begin
      wrAddrBus[i*AW +: AW] = AW'(i);
      wrDataBus[i*DW +: DW] = 8'h10 + DW'(i);
    end
    wrReq = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      #1;
      eg = 4'b0001 << (c % 4);
      total++;
      if (wrGnt !== eg) begin
        bad++;
        $display("FAIL rr_gnt c=%0d got=%b exp=%b", c, wrGnt, eg);
      end
      cyc();
      total++;
      if (ramWriteEnable !== 1'b1 || ramChipSelect !== 1'b1 ||
          ramWriteAddr !== AW'(c % 4) || ramDataIn !== 8'h10 + DW'(c % 4)) begin
        bad++;
        $display("FAIL rr_wr c=%0d we=%b cs=%b addr=%h data=%h exp we=1 cs=1 addr=%h data=%h",
                 c, ramWriteEnable, ramChipSelect, ramWriteAddr, ramDataIn, c % 4, 8'h10 + c % 4);
      end
    end
    wrReq = '0;
    rdAddrBus = {4'd3, 4'd2, 4'd1, 4'd0};
    rdReq = 4'b1111;
    #1;
    total++;
    if (rdGnt !== 4'b1111) begin
      bad++;
      $display("FAIL rr_rdgnt got=%b exp=1111", rdGnt);
    end
    cyc();
    rdReq = '0;
    total++;
    if (ramReadEnable !== 1'b1 || ramReadAddrBus !== 16'h3210) begin
      bad++;
      $display("FAIL rr_raddr re=%b addr=%h exp re=1 addr=3210", ramReadEnable, ramReadAddrBus);
    end
    cyc();
    total++;
    if (rdValid !== 4'b1111 || rdDataBus !== 32'h13121110) begin
      bad++;
      $display("FAIL rr_rdata vld=%b data=%h exp vld=1111 data=13121110", rdValid, rdDataBus);
    end
    cyc();
    total++;
    if (rdValid !== 4'b0000) begin
      bad++;
      $display("FAIL rr_vld_pulse got=%b exp=0000", rdValid);
    end
  endtask

  task automatic test_single_writer;
    wrAddrBus[2*AW +: AW] = 4'd7;
    wrDataBus[2*DW +: DW] = 8'h77;
    wrReq = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++;
      if (wrGnt !== 4'b0100) begin
        bad++;
        $display("FAIL single_gnt c=%0d got=%b exp=0100", c, wrGnt);
      end
      cyc();
    end
    wrAddrBus[0 +: AW] = 4'd10;
    wrReq = 4'b0101;
    #1;
    total++;
    if (wrGnt !== 4'b0001) begin
      bad++;
      $display("FAIL single_ptr got=%b exp=0001", wrGnt);
    end
    cyc();
    wrReq = '0;
    cyc();
  endtask

  task automatic test_hazard;
    wrAddrBus[0 +: AW] = 4'd5;
    wrDataBus[0 +: DW] = 8'hA5;
    rdAddrBus[1*AW +: AW] = 4'd5;
    wrReq = 4'b0001;
    rdReq = 4'b0010;
    #1;
    total++;
    if (wrGnt !== 4'b0001 || rdGnt !== 4'b0000) begin
      bad++;
      $display("FAIL haz_block wgnt=%b rgnt=%b exp wgnt=0001 rgnt=0000", wrGnt, rdGnt);
    end
    cyc();
    wrReq = '0;
    #1;
    total++;
    if (rdGnt !== 4'b0010 || rdValid !== 4'b0000) begin
      bad++;
      $display("FAIL haz_retry rgnt=%b vld=%b exp rgnt=0010 vld=0000", rdGnt, rdValid);
    end
    cyc();
    rdReq = '0;
    cyc();
    total++;
    if (rdValid !== 4'b0010 || rdDataBus[1*DW +: DW] !== 8'hA5) begin
      bad++;
      $display("FAIL haz_data vld=%b data=%h exp vld=0010 data=a5", rdValid, rdDataBus[1*DW +: DW]);
    end
    cyc();
  endtask

  task automatic test_multi_read;
    wrReq = 4'b0001;
    for (int c = 1; c <= 4; c++) begin
      wrAddrBus[0 +: AW] = AW'(c);
      wrDataBus[0 +: DW] = DW'(c);
      cyc();
    end
    wrAddrBus[1*AW +: AW] = 4'd9;
    wrDataBus[1*DW +: DW] = 8'h99;
    wrReq = 4'b0010;
    rdAddrBus = {4'd4, 4'd3, 4'd2, 4'd1};
    rdReq = 4'b1111;
    #1;
    total++;
    if (rdGnt !== 4'b1111 || wrGnt !== 4'b0010) begin
      bad++;
      $display("FAIL multi_gnt rgnt=%b wgnt=%b exp rgnt=1111 wgnt=0010", rdGnt, wrGnt);
    end
    cyc();
    wrReq = '0;
    rdAddrBus = {4'd3, 4'd2, 4'd1, 4'd4};
    #1;
    total++;
    if (rdGnt !== 4'b1111 || ramReadAddrBus !== 16'h4321 || ramWriteEnable !== 1'b1) begin
      bad++;
      $display("FAIL multi_issue rgnt=%b raddr=%h we=%b exp rgnt=1111 raddr=4321 we=1", rdGnt, ramReadAddrBus, ramWriteEnable);
    end
    cyc();
    rdReq = '0;
    total++;
    if (rdValid !== 4'b1111 || rdDataBus !== 32'h04030201) begin
      bad++;
      $display("FAIL multi_rd0 vld=%b data=%h exp vld=1111 data=04030201", rdValid, rdDataBus);
    end
    cyc();
    total++;
    if (rdValid !== 4'b1111 || rdDataBus !== 32'h03020104) begin
      bad++;
      $display("FAIL multi_rd1 vld=%b data=%h exp vld=1111 data=03020104", rdValid, rdDataBus);
    end
    cyc();
    total++;
    if (rdValid !== 4'b0000) begin
      bad++;
      $display("FAIL multi_end vld=%b exp=0000", rdValid);
    end
  endtask

  task automatic test_reset_midread;
    rdAddrBus[0 +: AW] = 4'd1;
    rdReq = 4'b0001;
    #1;
    cyc();
    rdReq = '0;
    total++;
    if (ramReadEnable !== 1'b1 || ramChipSelect !== 1'b1) begin
      bad++;
      $display("FAIL mid_issue re=%b cs=%b exp re=1 cs=1", ramReadEnable, ramChipSelect);
    end
    #2;
    Rst_n = 1'b0;
    #1;
    total++;
    if ({ramChipSelect, ramWriteEnable, ramReadEnable, ramReadAddrBus, ramWriteAddr, ramDataIn, rdValid} !== '0) begin
      bad++;
      $display("FAIL mid_zero cs=%b we=%b re=%b raddr=%h waddr=%h din=%h vld=%b exp=all zero",
               ramChipSelect, ramWriteEnable, ramReadEnable, ramReadAddrBus, ramWriteAddr, ramDataIn, rdValid);
    end
    cyc();
    cyc();
    Rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      cyc();
      total++;
      if (rdValid !== 4'b0000) begin
        bad++;
        $display("FAIL mid_novld c=%0d got=%b exp=0000", c, rdValid);
      end
    end
  endtask

`ifdef SYNCRAM_INIT_CLEAR_EN
  task automatic test_clear_sweep;
    int n;
    Rst_n = 1'b0;
    cyc();
    Rst_n = 1'b1;
    for (int c = 0; c < 5; c++) cyc();
    total++;
    if (busy !== 1'b1 || ramWriteAddr !== 4'd4) begin
      bad++;
      $display("FAIL sweep_prog busy=%b addr=%h exp busy=1 addr=4", busy, ramWriteAddr);
    end
    Rst_n = 1'b0;
    #1;
    total++;
    if (busy !== 1'b1 || ramWriteAddr !== 4'd0) begin
      bad++;
      $display("FAIL sweep_rst busy=%b addr=%h exp busy=1 addr=0", busy, ramWriteAddr);
    end
    cyc();
    Rst_n = 1'b1;
    cyc();
    total++;
    if (ramWriteAddr !== 4'd0 || ramWriteEnable !== 1'b1 || ramDataIn !== 8'h00) begin
      bad++;
      $display("FAIL sweep_restart addr=%h we=%b din=%h exp addr=0 we=1 din=00", ramWriteAddr, ramWriteEnable, ramDataIn);
    end
    n = 1;
    while (busy === 1'b1 && n < 40) begin
      n++;
      cyc();
    end
    total++;
    if (n != 16) begin
      bad++;
      $display("FAIL sweep_len got=%0d exp=16", n);
    end
    rdAddrBus[3*AW +: AW] = 4'd9;
    rdReq = 4'b1000;
    #1;
    cyc();
    rdReq = '0;
    cyc();
    total++;
    if (rdValid !== 4'b1000 || rdDataBus[3*DW +: DW] !== 8'h00) begin
      bad++;
      $display("FAIL sweep_zero vld=%b data=%h exp vld=1000 data=00", rdValid, rdDataBus[3*DW +: DW]);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_rr_all();
    test_single_writer();
    test_hazard();
    test_multi_read();
    test_reset_midread();
`ifdef SYNCRAM_INIT_CLEAR_EN
    test_clear_sweep();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/syncram_access_ctrl.md
Name: syncram_access_ctrl

Overview:
- Sequences and shares the 1-write / 4-read synchronous RAM (`syncRAM`) between four writers and four readers.
- Arbitrates the single write port round-robin.
- Maps read client i onto RAM read port i.
- Blocks same-address read-during-write hazards and returns read data with a valid strobe.
- Sits directly in front of `syncRAM`, registering every RAM control/address/data input.

Parameters:
- AW, 8, address width (RAM depth = 2**AW)
- DW, 8, data width
- NCLI, 4, clients per side; fixed at 4 to match the RAM read ports

Ports:
- Clk  in  1  system clock, rising edge
- Rst_n  in  1  asynchronous active-low reset
- wrReq  in  4  write request, bit i = writer i; held until granted
- wrAddrBus  in  4*AW  writer i address at [i*AW +: AW]
- wrDataBus  in  4*DW  writer i data at [i*DW +: DW]
- wrGnt  out  4  one-hot, combinational; high = write accepted this cycle
- rdReq  in  4  read request, bit i = reader i; held until granted
- rdAddrBus  in  4*AW  reader i address
- rdGnt  out  4  combinational; high = read accepted this cycle
- rdDataBus  out  4*DW  reader i data, valid when rdValid[i]
- rdValid  out  4  registered one-cycle pulse per accepted read
- busy  out  1  high while the init-clear sweep runs
- ramDataIn  out  DW  to RAM dataIn
- ramWriteAddr  out  AW  to RAM writeAddr
- ramReadAddrBus  out  4*AW  to RAM readAddr_0..3
- ramChipSelect  out  1  to RAM chipSelect
- ramWriteEnable  out  1  to RAM writeEnable
- ramReadEnable  out  1  to RAM readEnable
- ramDOutBus  in  4*DW  from RAM dOut_0..3

Behaviour:
- Reset (Rst_n low, async):
  - All registered outputs 0: ram* strobes, addresses, data, rdValid, rdDataBus.
  - RR pointer = 0, so writer 0 has highest priority first.
  - FSM to CLR if SYNCRAM_INIT_CLEAR_EN is defined, else to RUN.
- FSM states:
  - CLR: clear counter runs 0..2**AW-1. Each cycle registers ramWriteAddr = counter, ramDataIn = 0, ramChipSelect = 1, ramWriteEnable = 1. busy = 1; wrGnt = rdGnt = 0. After the last address, go to RUN on the next cycle.
  - RUN: normal arbitration; busy = 0. Never leaves RUN except via reset.
- Write arbitration in RUN (cycle N):
  - Winner = first requesting writer scanning ptr, ptr+1, ... mod 4; wrGnt = one-hot winner.
  - At the N edge: ptr <= winner+1 mod 4; ramWriteAddr/ramDataIn <= winner's address/data; ramWriteEnable <= 1.
  - With no request, ramWriteEnable <= 0 and ptr holds.
- Reads in RUN (cycle N):
  - rdGnt[i] = rdReq[i] AND NOT (a write is granted in N AND rdAddr_i == that write address). Hazard-blocked readers retry the next cycle and then see the new data.
  - At the N edge: ramReadAddr_i <= rdAddr_i for each granted i. Ungranted ports hold their old address.
  - ramReadEnable <= OR(rdGnt).
- ramChipSelect <= 1 whenever a write or any read is issued, else 0.
- Timing:
  - RAM strobes are active in N+1; RAM write and read capture happen at the N+1 edge.
  - rdValid[i] = 1 and rdDataBus slice i <= ramDOutBus slice i in N+2 (read latency 2 from grant).
  - Write visible to a read granted at N+1 or later.
- Simultaneous events: all 4 reads plus 1 write can issue in the same cycle; reads to different addresses than the write are never blocked.
- Reset mid-operation: in-flight writes and reads are dropped, with no rdValid. The clear sweep restarts from address 0 when enabled.

Optional Feature:
- Macro SYNCRAM_INIT_CLEAR_EN.
- Defined: post-reset CLR sweep zero-fills all 2**AW locations (2**AW cycles, busy high, all grants low).
- Undefined: no CLR state or counter; RUN immediately after reset; busy tied 0; RAM contents undefined until written.

Test Plan:
- Writers 0-3 request continuously with addr = i, data = 8'h10+i -> wrGnt order 0,1,2,3,0 in consecutive cycles; RAM addr i holds 8'h10+i.
- Only writer 2 requests, for 3 cycles -> granted every cycle; ptr advances to 3 each time; other grants stay 0.
- Write addr 8'h05 = 8'hA5 and reader 1 reads 8'h05 in the same cycle -> rdGnt[1] = 0 in that cycle, 1 in the next; rdValid[1] pulses 2 cycles later with 8'hA5.
- After writing 1,2,3,4 to addrs 1-4, all readers request in one cycle with addrs (1,2,3,4) then rotated (4,1,2,3) -> rdValid = 4'hF twice; data matches the rotation.
- With SYNCRAM_INIT_CLEAR_EN, AW = 4: busy high exactly 16 cycles after reset release, then any read returns 8'h00; assert Rst_n low mid-sweep -> busy stays high and the sweep restarts at 0.
- Drop Rst_n during an outstanding read -> rdValid never pulses for it; all ram* outputs read 0 immediately.
